// File: rtl/cache_fence_ctrl_pkg.sv
// cache_fence_ctrl_pkg: shared state and fence-type encodings for the cache fence sequencer.
package cache_fence_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN_AMO, WAIT_WB, FLUSH_D, FLUSH_I, DONE} fence_state_e;
  typedef enum logic {FENCE_D = 1'b0, FENCE_I = 1'b1} fence_type_e;
endpackage

// File: rtl/cache_fence_ctrl.sv
// cache_fence_ctrl: sequences AMO drain, write-buffer wait, D$ flush and I$ flush for FENCE/FENCE.I.
// Optional per-state wait timeout enabled by defining CACHE_FENCE_TIMEOUT_EN.
module cache_fence_ctrl
  import cache_fence_ctrl_pkg::*;
#(
  parameter int CntWidth = 16
`ifdef CACHE_FENCE_TIMEOUT_EN
  , parameter int TimeoutCycles = 1024
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_valid_i,
  input  logic                fence_is_i_i,
  input  logic                dcache_enable_i,
  input  logic                amo_busy_i,
  input  logic                wbuffer_empty_i,
  output logic                dcache_flush_o,
  input  logic                dcache_flush_ack_i,
  output logic                icache_flush_o,
  output logic                fence_ack_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] fence_cnt_o
`ifdef CACHE_FENCE_TIMEOUT_EN
  , output logic              timeout_o
`endif
);
  fence_state_e        r_state;
  fence_state_e        w_next;
  fence_state_e        w_state_d;
  fence_state_e        w_after_d;
  fence_type_e         r_type;
  logic [CntWidth-1:0] r_cnt;
  logic                w_timed_out;
  assign w_after_d = (r_type == FENCE_I) ? FLUSH_I : DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = fence_valid_i ? DRAIN_AMO : IDLE;
      DRAIN_AMO: w_next = amo_busy_i ? DRAIN_AMO : WAIT_WB;
      WAIT_WB:   w_next = !wbuffer_empty_i ? WAIT_WB : dcache_enable_i ? FLUSH_D : w_after_d;
      FLUSH_D:   w_next = dcache_flush_ack_i ? w_after_d : FLUSH_D;
      FLUSH_I:   w_next = DONE;
      default:   w_next = IDLE;
    endcase
  end
`ifdef CACHE_FENCE_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);
  logic [WaitW-1:0] r_wait;
  logic             r_timeout;
  logic             w_timeout;
  // A wait state that would still be held after its last allowed cycle aborts to DONE
  assign w_timeout = (r_state inside {DRAIN_AMO, WAIT_WB, FLUSH_D}) && (w_next == r_state) &&
                     (r_wait == WaitW'(TimeoutCycles - 1));
  assign w_state_d   = w_timeout ? DONE : w_next;
  assign w_timed_out = r_timeout;
  assign timeout_o   = r_timeout;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait    <= (w_state_d != r_state) ? '0 : r_wait + 1'b1;
      r_timeout <= w_timeout;
    end
  end
`else
  assign w_state_d   = w_next;
  assign w_timed_out = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_type  <= FENCE_D;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && fence_valid_i) r_type <= fence_type_e'(fence_is_i_i);
      if (r_state == DONE && !w_timed_out && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign dcache_flush_o = (r_state == FLUSH_D);
  assign icache_flush_o = (r_state == FLUSH_I);
  assign fence_ack_o    = (r_state == DONE);
  assign busy_o         = (r_state != IDLE);
  assign fence_cnt_o    = r_cnt;
endmodule

// File: tb/tb_cache_fence_ctrl.sv
// tb_cache_fence_ctrl: directed and randomized fence sequences checked against cycle-arithmetic expectations.
module tb_cache_fence_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fence_valid_i = 1'b0, fence_is_i_i = 1'b0, dcache_enable_i = 1'b0;
  logic        amo_busy_i = 1'b0, wbuffer_empty_i = 1'b0, dcache_flush_ack_i = 1'b0;
  logic        dcache_flush_o, icache_flush_o, fence_ack_o, busy_o;
  logic [15:0] fence_cnt_o;
  int          checks = 0, errors = 0, exp_cnt = 0;
`ifdef CACHE_FENCE_TIMEOUT_EN
  logic timeout_o;
  cache_fence_ctrl #(.CntWidth(16), .TimeoutCycles(8)) dut (
`else
  cache_fence_ctrl #(.CntWidth(16)) dut (
`endif
    .clk_i(clk_i), .rst_ni(rst_ni), .fence_valid_i(fence_valid_i), .fence_is_i_i(fence_is_i_i),
    .dcache_enable_i(dcache_enable_i), .amo_busy_i(amo_busy_i), .wbuffer_empty_i(wbuffer_empty_i),
    .dcache_flush_o(dcache_flush_o), .dcache_flush_ack_i(dcache_flush_ack_i),
    .icache_flush_o(icache_flush_o), .fence_ack_o(fence_ack_o), .busy_o(busy_o),
    .fence_cnt_o(fence_cnt_o)
`ifdef CACHE_FENCE_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      fence_valid_i = 1'b0; fence_is_i_i = rnd(); dcache_enable_i = rnd();
      amo_busy_i = rnd(); wbuffer_empty_i = rnd(); dcache_flush_ack_i = rnd();
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_dflush", dcache_flush_o, 0);
      chk("idle_iflush", icache_flush_o, 0);
      chk("idle_ack", fence_ack_o, 0);
      chk("idle_cnt", fence_cnt_o, exp_cnt);
    end
  endtask
  // Cycle t=0 is the request cycle; a = AMO-busy cycles, w = extra wbuffer-full cycles, k = flush-ack delay.
  task automatic run_fence(input bit ty, input bit en, input int a, input int w, input int k, input bit mid);
    int tf, ti, td;
    tf = 3 + a + w;
    ti = !ty ? -1 : en ? 4 + a + w + k : 3 + a + w;
    td = ty ? ti + 1 : en ? 4 + a + w + k : 3 + a + w;
    for (int t = 0; t <= td; t++) begin
      @(posedge clk_i); #1;
      fence_valid_i      = (t == 0) || (mid && (t == 2 + a || rnd()));
      fence_is_i_i       = (t == 0) ? ty : rnd();
      amo_busy_i         = (t >= 1 && t <= a) ? 1'b1 : (t == a + 1) ? 1'b0 : rnd();
      wbuffer_empty_i    = (t >= 2 + a + w) ? 1'b1 : (t < 2 + a) ? rnd() : 1'b0;
      dcache_enable_i    = (t == 2 + a + w) ? en : rnd();
      dcache_flush_ack_i = (!en || t < tf || t > tf + k) ? rnd() : (t == tf + k);
      @(negedge clk_i);
      if (t == 0) chk("start_cnt", fence_cnt_o, exp_cnt);
      chk("busy", busy_o, t != 0);
      chk("dflush", dcache_flush_o, en && t >= tf && t <= tf + k);
      chk("iflush", icache_flush_o, t == ti);
      chk("ack", fence_ack_o, t == td);
`ifdef CACHE_FENCE_TIMEOUT_EN
      chk("no_timeout", timeout_o, 0);
`endif
    end
    if (exp_cnt < 65535) exp_cnt++;
  endtask
  initial begin
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_dflush", dcache_flush_o, 0);
    chk("rst_iflush", icache_flush_o, 0);
    chk("rst_ack", fence_ack_o, 0);
    chk("rst_cnt", fence_cnt_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle(2);
    run_fence(1'b1, 1'b1, 0, 0, 0, 1'b0);
    idle(1);
    chk("cnt_after_fencei", fence_cnt_o, 1);
    run_fence(1'b0, 1'b1, 4, 3, 2, 1'b0);
    run_fence(1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Reset while FLUSH_D is waiting for its ack
    for (int t = 0; t <= 4; t++) begin
      @(posedge clk_i); #1;
      fence_valid_i = (t == 0); fence_is_i_i = 1'b0; amo_busy_i = 1'b0;
      wbuffer_empty_i = 1'b1; dcache_enable_i = 1'b1; dcache_flush_ack_i = 1'b0;
      @(negedge clk_i);
      chk("pre_rst_dflush", dcache_flush_o, t >= 3);
    end
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_dflush", dcache_flush_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ack", fence_ack_o, 0);
    chk("mid_rst_cnt", fence_cnt_o, 0);
    exp_cnt = 0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle(3);
    run_fence(1'b0, 1'b1, 1, 2, 1, 1'b1);
    run_fence(1'b1, 1'b1, 0, 0, 0, 1'b0);
    idle(1);
    chk("b2b_cnt", fence_cnt_o, 2);
    for (int i = 0; i < 40; i++) begin
      run_fence(rnd(), rnd(), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), rnd());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
`ifdef CACHE_FENCE_TIMEOUT_EN
    for (int t = 0; t <= 12; t++) begin
      @(posedge clk_i); #1;
      fence_valid_i = (t == 0); fence_is_i_i = 1'b0; amo_busy_i = 1'b0;
      wbuffer_empty_i = 1'b1; dcache_enable_i = 1'b1; dcache_flush_ack_i = 1'b0;
      @(negedge clk_i);
      chk("to_dflush", dcache_flush_o, t >= 3 && t <= 10);
      chk("to_ack", fence_ack_o, t == 11);
      chk("to_flag", timeout_o, t == 11);
      chk("to_cnt", fence_cnt_o, exp_cnt);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
